// File: rtl/branch_predictor_2bit_if.sv
// Fetch/execute port bundle for the 2-bit branch target buffer.
// The master drives lookups, updates and invalidates; the slave is the predictor.
interface branch_predictor_2bit_if #(
  parameter int PC_W   = 32,
  parameter int STAT_W = 32
);
  logic [PC_W-1:0]   i_fetch_pc;
  logic              o_hit;
  logic              o_pred_taken;
  logic [PC_W-1:0]   o_pred_pc;
  logic              i_upd_vld;
  logic [PC_W-1:0]   i_upd_pc;
  logic              i_upd_is_jump;
  logic              i_upd_taken;
  logic [PC_W-1:0]   i_upd_target;
  logic              i_upd_mispred;
  logic              i_inv_all;
  logic [STAT_W-1:0] o_stat_ctrl;
  logic [STAT_W-1:0] o_stat_mispred;

  modport master (
    output i_fetch_pc, i_upd_vld, i_upd_pc, i_upd_is_jump, i_upd_taken,
           i_upd_target, i_upd_mispred, i_inv_all,
    input  o_hit, o_pred_taken, o_pred_pc, o_stat_ctrl, o_stat_mispred
  );

  modport slave (
    input  i_fetch_pc, i_upd_vld, i_upd_pc, i_upd_is_jump, i_upd_taken,
           i_upd_target, i_upd_mispred, i_inv_all,
    output o_hit, o_pred_taken, o_pred_pc, o_stat_ctrl, o_stat_mispred
  );
endinterface

// File: rtl/branch_predictor_2bit.sv
// Direct-mapped BTB with a 2-bit saturating direction counter per entry,
// combinational fetch lookup, execute-stage writeback and saturating debug statistics.
module branch_predictor_2bit #(
  parameter int         ENTRIES  = 64,
  parameter int         PC_W     = 32,
  parameter logic [1:0] CNT_INIT = 2'b01,
  parameter int         STAT_W   = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  branch_predictor_2bit_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  if ((ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_param_guard
    $error("branch_predictor_2bit: ENTRIES must be a power of 2 and at least 2");
  end

  logic [ENTRIES-1:0] r_valid;
  logic [1:0]         r_cnt    [ENTRIES];
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [PC_W-1:0]    r_target [ENTRIES];
  logic [STAT_W-1:0]  r_stat_ctrl;
  logic [STAT_W-1:0]  r_stat_mispred;

  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic             w_f_hit;
  logic             w_f_taken;
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;
  logic             w_u_taken;
  logic             w_accept;
  logic             w_wr_alloc;
  logic             w_wr_target;
  logic             w_wr_cnt;
  logic [1:0]       w_new_cnt;
  logic [1:0]       w_cur_cnt;
  logic [3:0]       w_unused_pc_lsbs;

  assign w_unused_pc_lsbs = {bus.i_fetch_pc[1:0], bus.i_upd_pc[1:0]};

  assign w_f_idx   = bus.i_fetch_pc[IDX_W+1:2];
  assign w_f_tag   = bus.i_fetch_pc[PC_W-1:IDX_W+2];
  assign w_f_hit   = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_f_taken = w_f_hit && r_cnt[w_f_idx][1];

  // Lookup reads registered state only, so a same-cycle update is not visible yet.
  assign bus.o_hit          = w_f_hit;
  assign bus.o_pred_taken   = w_f_taken;
  assign bus.o_pred_pc      = w_f_taken ? r_target[w_f_idx]
                                        : bus.i_fetch_pc + {{(PC_W-3){1'b0}}, 3'b100};
  assign bus.o_stat_ctrl    = r_stat_ctrl;
  assign bus.o_stat_mispred = r_stat_mispred;

  assign w_u_idx   = bus.i_upd_pc[IDX_W+1:2];
  assign w_u_tag   = bus.i_upd_pc[PC_W-1:IDX_W+2];
  assign w_u_hit   = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_u_taken = bus.i_upd_taken || bus.i_upd_is_jump;
  assign w_accept  = bus.i_upd_vld && !bus.i_inv_all && !i_reset;
  assign w_cur_cnt = r_cnt[w_u_idx];

  // Decide what the resolved outcome writes into the indexed entry.
  always_comb begin
    w_wr_alloc  = 1'b0;
    w_wr_target = 1'b0;
    w_wr_cnt    = 1'b0;
    w_new_cnt   = w_cur_cnt;
    if (!w_accept) begin
      w_wr_cnt = 1'b0;
    end else if (w_u_hit) begin
      w_wr_cnt = 1'b1;
      if (bus.i_upd_is_jump) begin
        w_new_cnt   = 2'b11;
        w_wr_target = 1'b1;
      end else if (bus.i_upd_taken) begin
        w_new_cnt   = (w_cur_cnt == 2'b11) ? 2'b11 : w_cur_cnt + 2'b01;
        w_wr_target = 1'b1;
      end else begin
        w_new_cnt   = (w_cur_cnt == 2'b00) ? 2'b00 : w_cur_cnt - 2'b01;
      end
    end else if (w_u_taken) begin
      w_wr_alloc  = 1'b1;
      w_wr_target = 1'b1;
      w_wr_cnt    = 1'b1;
      w_new_cnt   = bus.i_upd_is_jump ? 2'b11 : 2'b10;
    end else begin
      w_wr_cnt = 1'b0;
    end
  end

  // Valid bits, counters and statistics: reset beats invalidate beats update.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= CNT_INIT;
      end
      r_stat_ctrl    <= {STAT_W{1'b0}};
      r_stat_mispred <= {STAT_W{1'b0}};
    end else if (bus.i_inv_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= CNT_INIT;
      end
    end else begin
      if (w_wr_alloc) begin
        r_valid[w_u_idx] <= 1'b1;
      end
      if (w_wr_cnt) begin
        r_cnt[w_u_idx] <= w_new_cnt;
      end
      if (w_accept && (r_stat_ctrl != {STAT_W{1'b1}})) begin
        r_stat_ctrl <= r_stat_ctrl + {{(STAT_W-1){1'b0}}, 1'b1};
      end
      if (w_accept && bus.i_upd_mispred && (r_stat_mispred != {STAT_W{1'b1}})) begin
        r_stat_mispred <= r_stat_mispred + {{(STAT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Tag/target arrays carry no reset so they can map onto async-read LUT-RAM.
  always_ff @(posedge i_clk) begin
    if (w_wr_alloc) begin
      r_tag[w_u_idx] <= w_u_tag;
    end
    if (w_wr_target) begin
      r_target[w_u_idx] <= bus.i_upd_target;
    end
  end
endmodule
